nec_ir_decoder: RTL and testbench

//  Parametrised NEC IR frame decoder; successor to the single-mode direction receiver.

---
 rtl/nec_pkg.sv | 14 +
 rtl/nec_if.sv | 20 ++
 rtl/ir_sync_edge.sv | 22 ++
 rtl/nec_ir_decoder.sv | 161 ++++++++++++++++
 tb/tb_nec_ir_decoder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/nec_pkg.sv
// nec_pkg: shared types and default constants for the NEC IR decoder.
//   nec_state_t  decoder FSM states
//   dir_t        snake direction (UP, DOWN, LEFT, RIGHT)
//   NEC_BITS     data bits per frame
//   DEF_KEY_*    default key words, MSB-first shift order
package nec_pkg;
    typedef enum logic [2:0] {IDLE, LDR_MARK, LDR_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} nec_state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    localparam int NEC_BITS = 32;
    localparam logic [31:0] DEF_KEY_UP    = 32'h20DF6A95;
    localparam logic [31:0] DEF_KEY_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] DEF_KEY_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] DEF_KEY_RIGHT = 32'h20DF9A65;
endpackage

// File: rtl/nec_if.sv
// nec_if: decoder-facing bundle.
//   i_ir_signal     demodulated IR line (0 = mark, 1 = space/idle)
//   o_code          last valid frame word
//   o_frame_valid   strobe: new valid frame
//   o_repeat_valid  strobe: accepted repeat code
//   o_frame_error   strobe: malformed frame, timeout or check failure
//   o_direction     held direction
//   o_dir_valid     strobe: direction updated
// master = decoder side, slave = IR source / game side.
interface nec_if;
    logic               i_ir_signal;
    logic [31:0]        o_code;
    logic               o_frame_valid;
    logic               o_repeat_valid;
    logic               o_frame_error;
    nec_pkg::dir_t      o_direction;
    logic               o_dir_valid;
    modport master (input i_ir_signal, output o_code, o_frame_valid, o_repeat_valid, o_frame_error, o_direction, o_dir_valid);
    modport slave (output i_ir_signal, input o_code, o_frame_valid, o_repeat_valid, o_frame_error, o_direction, o_dir_valid);
endinterface

// File: rtl/ir_sync_edge.sv
// ir_sync_edge: 2-flop synchronizer with rise/fall detection on the synced value.
//   i_clk    sample tick
//   i_rst_n  asynchronous active-low reset (flops reset to 1 = idle line)
//   i_d      asynchronous input
//   o_rise   synced value went 0 -> 1
//   o_fall   synced value went 1 -> 0
module ir_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    // [0],[1]: synchronizer; [2]: previous synced value for edge detection
    logic [2:0] r_sh;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sh <= '1;
        else r_sh <= {r_sh[1:0], i_d};
    end
    assign o_rise = r_sh[1] & ~r_sh[2];
    assign o_fall = ~r_sh[1] & r_sh[2];
endmodule

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: NEC IR frame decoder mapping four key codes to a held snake direction.
//   i_nec_clk  sample tick (~56 us)
//   i_reset_n  asynchronous active-low reset
//   bus        nec_if.master: IR input, code/direction outputs and strobes
// Optional feature macro NEC_REPEAT_EN: accept repeat codes after a valid frame.
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int unsigned LEADER_MARK_MIN  = 144,
    parameter int unsigned SPACE_SPLIT      = 60,
    parameter int unsigned REPEAT_SPACE_MIN = 30,
    parameter int unsigned BIT_THRESH       = 20,
    parameter int unsigned TIMEOUT          = 200,
    parameter int unsigned CNT_W            = 8,
    parameter bit          CHECK_ADDR_INV   = 1'b1,
    parameter logic [31:0] KEY_UP           = DEF_KEY_UP,
    parameter logic [31:0] KEY_DOWN         = DEF_KEY_DOWN,
    parameter logic [31:0] KEY_LEFT         = DEF_KEY_LEFT,
    parameter logic [31:0] KEY_RIGHT        = DEF_KEY_RIGHT
) (
    input  logic i_nec_clk,
    input  logic i_reset_n,
    nec_if.master bus
);
    localparam logic [CNT_W-1:0] L_LDR   = CNT_W'(LEADER_MARK_MIN);
    localparam logic [CNT_W-1:0] L_SPLIT = CNT_W'(SPACE_SPLIT);
    localparam logic [CNT_W-1:0] L_RPT   = CNT_W'(REPEAT_SPACE_MIN);
    localparam logic [CNT_W-1:0] L_BIT   = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] L_TO    = CNT_W'(TIMEOUT);
    localparam logic [4:0]       L_LAST  = 5'(NEC_BITS - 1);

    nec_state_t       r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit, w_bit_n;
    logic [31:0]      r_sr, w_sr_n, r_code, w_code_n;
    logic             r_rpt, w_rpt_n;
    dir_t             r_dir, w_dir_n, w_key_dir;
    logic             r_fv, w_fv_n, r_err, w_err_n, r_dv, w_dv_n;
    logic             w_rise, w_fall, w_hit, w_chk_ok;
`ifdef NEC_REPEAT_EN
    logic             r_rv, w_rv_n, r_have, w_have_n;
`endif

    ir_sync_edge u_sync (
        .i_clk   (i_nec_clk),
        .i_rst_n (i_reset_n),
        .i_d     (bus.i_ir_signal),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_chk_ok  = (r_sr[15:8] == ~r_sr[7:0]) && (!CHECK_ADDR_INV || (r_sr[31:24] == ~r_sr[23:16]));
    assign w_hit     = r_sr inside {KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    assign w_key_dir = (r_sr == KEY_DOWN) ? DOWN : (r_sr == KEY_LEFT) ? LEFT : (r_sr == KEY_RIGHT) ? RIGHT : UP;

    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_sr_n    = r_sr;
        w_rpt_n   = r_rpt;
        w_code_n  = r_code;
        w_dir_n   = r_dir;
        w_fv_n    = 1'b0;
        w_err_n   = 1'b0;
        w_dv_n    = 1'b0;
`ifdef NEC_REPEAT_EN
        w_rv_n    = 1'b0;
        w_have_n  = r_have;
`endif
        // Timeout outranks any edge arriving in the same tick
        if (r_state != IDLE && r_cnt == L_TO) begin
            w_err_n   = 1'b1;
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE:      if (w_fall) w_state_n = LDR_MARK;
                LDR_MARK:  if (w_rise) w_state_n = (r_cnt >= L_LDR) ? LDR_SPACE : IDLE;
                LDR_SPACE: if (w_fall) begin
                    w_bit_n   = '0;
                    w_rpt_n   = r_cnt < L_SPLIT;
                    w_err_n   = r_cnt < L_RPT;
                    w_state_n = (r_cnt >= L_SPLIT) ? BIT_MARK : (r_cnt >= L_RPT) ? STOP_MARK : IDLE;
                end
                BIT_MARK:  if (w_rise) w_state_n = BIT_SPACE;
                BIT_SPACE: if (w_fall) begin
                    w_sr_n    = {r_sr[30:0], r_cnt >= L_BIT};
                    w_bit_n   = r_bit + 5'd1;
                    w_state_n = (r_bit == L_LAST) ? STOP_MARK : BIT_MARK;
                end
                STOP_MARK: if (w_rise) begin
                    w_state_n = IDLE;
                    if (r_rpt) begin
`ifdef NEC_REPEAT_EN
                        w_rv_n = r_have;
                        w_dv_n = r_have;
`endif
                    end else if (w_chk_ok) begin
                        w_code_n = r_sr;
                        w_fv_n   = 1'b1;
                        w_dv_n   = w_hit;
                        w_dir_n  = w_hit ? w_key_dir : r_dir;
`ifdef NEC_REPEAT_EN
                        w_have_n = 1'b1;
`endif
                    end else begin
                        w_err_n = 1'b1;
                    end
                end
                default:   w_state_n = IDLE;
            endcase
        end
`ifdef NEC_REPEAT_EN
        if (w_err_n) w_have_n = 1'b0;
`endif
    end

    always_ff @(posedge i_nec_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sr    <= '0;
            r_rpt   <= 1'b0;
            r_code  <= '0;
            r_dir   <= UP;
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
            r_dv    <= 1'b0;
`ifdef NEC_REPEAT_EN
            r_rv    <= 1'b0;
            r_have  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_cnt   <= (w_rise || w_fall) ? '0 : (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
            r_bit   <= w_bit_n;
            r_sr    <= w_sr_n;
            r_rpt   <= w_rpt_n;
            r_code  <= w_code_n;
            r_dir   <= w_dir_n;
            r_fv    <= w_fv_n;
            r_err   <= w_err_n;
            r_dv    <= w_dv_n;
`ifdef NEC_REPEAT_EN
            r_rv    <= w_rv_n;
            r_have  <= w_have_n;
`endif
        end
    end

    assign bus.o_code        = r_code;
    assign bus.o_frame_valid = r_fv;
    assign bus.o_frame_error = r_err;
    assign bus.o_direction   = r_dir;
    assign bus.o_dir_valid   = r_dv;
`ifdef NEC_REPEAT_EN
    assign bus.o_repeat_valid = r_rv;
`else
    assign bus.o_repeat_valid = 1'b0;
`endif
endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder: table-driven, directed and randomized checks of nec_ir_decoder.
module tb_nec_ir_decoder;
    typedef struct { int fv; int rv; int err; int dv; logic [31:0] code; logic [1:0] dir; } exp_t;
    typedef struct { logic [31:0] word; bit rpt; exp_t e; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int c_fv = 0, c_rv = 0, c_err = 0, c_dv = 0;
    logic [31:0] m_code = '0;
    logic [1:0]  m_dir = '0;
    bit          m_have = 1'b0;
    bit          rnd = 1'b0;
    logic [31:0] keys [4] = '{32'h20DF6A95, 32'h20DFEA15, 32'h20DF1AE5, 32'h20DF9A65};

    nec_if bus();
    nec_ir_decoder dut (.i_nec_clk(clk), .i_reset_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Strobe bookkeeping: count strobe ticks, enforce exclusivity and pairing of dir_valid
    always @(negedge clk) begin
        if (rst_n) begin
            c_fv  += int'(bus.o_frame_valid);
            c_rv  += int'(bus.o_repeat_valid);
            c_err += int'(bus.o_frame_error);
            c_dv  += int'(bus.o_dir_valid);
            if (bus.o_frame_valid | bus.o_repeat_valid | bus.o_frame_error | bus.o_dir_valid) begin
                check("strobe_onehot", 32'($countones({bus.o_frame_valid, bus.o_repeat_valid, bus.o_frame_error})), 1);
                if (bus.o_dir_valid) check("dir_valid_paired", {31'b0, bus.o_frame_valid | bus.o_repeat_valid}, 1);
            end
        end
    end

    // Reference: outcome of one complete frame from the protocol rules alone
    function automatic exp_t model(input logic [31:0] w, input bit rpt);
        exp_t e;
        e = '{0, 0, 0, 0, m_code, m_dir};
        if (rpt) begin
`ifdef NEC_REPEAT_EN
            if (m_have) begin
                e.rv = 1;
                e.dv = 1;
            end
`endif
        end else if (w[15:8] == ~w[7:0] && w[31:24] == ~w[23:16]) begin
            m_code = w;
            m_have = 1'b1;
            e.fv = 1;
            for (int k = 0; k < 4; k++) if (keys[k] == w) begin
                m_dir = 2'(k);
                e.dv = 1;
            end
        end else begin
            e.err = 1;
            m_have = 1'b0;
        end
        e.code = m_code;
        e.dir = m_dir;
        return e;
    endfunction

    function automatic exp_t snap();
        return '{c_fv, c_rv, c_err, c_dv, 32'h0, 2'b0};
    endfunction

    function automatic exp_t quiet(input int err);
        return '{0, 0, err, 0, m_code, m_dir};
    endfunction

    function automatic int dur(input int nom, input int lo, input int hi);
        return rnd ? int'($urandom_range(hi, lo)) : nom;
    endfunction

    task automatic seg(input logic lvl, input int n);
        bus.i_ir_signal = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w, input bit rpt, input int nbits);
        seg(1'b0, dur(160, 152, 190));
        seg(1'b1, rpt ? dur(40, 36, 54) : dur(80, 70, 120));
        if (!rpt) for (int i = 31; i > 31 - nbits; i--) begin
            seg(1'b0, dur(10, 6, 12));
            seg(1'b1, w[i] ? dur(30, 22, 32) : dur(10, 5, 12));
        end
        if (rpt || nbits == 32) seg(1'b0, dur(10, 6, 12));
    endtask

    task automatic compare(input string tag, input exp_t s, input exp_t e);
        check({tag, ".frame_valid"}, c_fv - s.fv, e.fv);
        check({tag, ".repeat_valid"}, c_rv - s.rv, e.rv);
        check({tag, ".frame_error"}, c_err - s.err, e.err);
        check({tag, ".dir_valid"}, c_dv - s.dv, e.dv);
        check({tag, ".code"}, bus.o_code, e.code);
        check({tag, ".direction"}, 32'(bus.o_direction), 32'(e.dir));
    endtask

    task automatic frame(input string tag, input logic [31:0] w, input bit rpt, input exp_t e);
        exp_t s;
        s = snap();
        send(w, rpt, 32);
        seg(1'b1, rnd ? int'($urandom_range(30, 6)) : 30);
        compare(tag, s, e);
    endtask

    initial begin
        vec_t tbl [9];
        exp_t e, s;
        logic [31:0] w, a;
        bit rpt;
        tbl[0] = '{32'h20DF6A95, 1'b0, '{1, 0, 0, 1, 32'h20DF6A95, 2'd0}};
        tbl[1] = '{32'h20DF9A65, 1'b0, '{1, 0, 0, 1, 32'h20DF9A65, 2'd3}};
`ifdef NEC_REPEAT_EN
        tbl[2] = '{32'h0, 1'b1, '{0, 1, 0, 1, 32'h20DF9A65, 2'd3}};
`else
        tbl[2] = '{32'h0, 1'b1, '{0, 0, 0, 0, 32'h20DF9A65, 2'd3}};
`endif
        tbl[3] = '{32'h20DF6A94, 1'b0, '{0, 0, 1, 0, 32'h20DF9A65, 2'd3}};
        tbl[4] = '{32'h12ED34CB, 1'b0, '{1, 0, 0, 0, 32'h12ED34CB, 2'd3}};
        tbl[5] = '{32'h20DF6A94, 1'b0, '{0, 0, 1, 0, 32'h12ED34CB, 2'd3}};
        tbl[6] = '{32'h0, 1'b1, '{0, 0, 0, 0, 32'h12ED34CB, 2'd3}};
        tbl[7] = '{32'h21DF6A95, 1'b0, '{0, 0, 1, 0, 32'h12ED34CB, 2'd3}};
        tbl[8] = '{32'h20DF1AE5, 1'b0, '{1, 0, 0, 1, 32'h20DF1AE5, 2'd2}};

        bus.i_ir_signal = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.code", bus.o_code, 0);
        check("reset.direction", 32'(bus.o_direction), 0);
        check("reset.strobes", {28'b0, bus.o_frame_valid, bus.o_repeat_valid, bus.o_frame_error, bus.o_dir_valid}, 0);
        rst_n = 1'b1;
        seg(1'b1, 10);

        for (int i = 0; i < 9; i++) begin
            void'(model(tbl[i].word, tbl[i].rpt));
            frame($sformatf("tbl%0d", i), tbl[i].word, tbl[i].rpt, tbl[i].e);
        end

        s = snap();
        seg(1'b0, 50);
        seg(1'b1, 40);
        seg(1'b0, 130);
        seg(1'b1, 40);
        compare("noise", s, quiet(0));
        frame("after_noise", 32'h20DF6A95, 1'b0, model(32'h20DF6A95, 1'b0));

        s = snap();
        seg(1'b0, 160);
        seg(1'b1, 15);
        seg(1'b0, 10);
        seg(1'b1, 40);
        m_have = 1'b0;
        compare("short_space", s, quiet(1));

        s = snap();
        seg(1'b0, 160);
        seg(1'b1, 80);
        seg(1'b0, 250);
        compare("timeout_low", s, quiet(1));
        seg(1'b1, 40);

        s = snap();
        seg(1'b0, 230);
        seg(1'b1, 40);
        compare("timeout_leader", s, quiet(1));

        s = snap();
        send(32'h20DF6A95, 1'b0, 5);
        seg(1'b1, 250);
        compare("timeout_space", s, quiet(1));
        frame("after_timeout_rpt", 32'h0, 1'b1, model(32'h0, 1'b1));
        frame("after_timeout", 32'h20DFEA15, 1'b0, model(32'h20DFEA15, 1'b0));

        s = snap();
        send(32'h20DFEA15, 1'b0, 17);
        seg(1'b0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.code", bus.o_code, 0);
        check("midreset.direction", 32'(bus.o_direction), 0);
        check("midreset.strobes", {28'b0, bus.o_frame_valid, bus.o_repeat_valid, bus.o_frame_error, bus.o_dir_valid}, 0);
        m_code = '0;
        m_dir = '0;
        m_have = 1'b0;
        bus.i_ir_signal = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        seg(1'b1, 20);
        compare("midreset", s, quiet(0));
        frame("after_reset", 32'h20DF1AE5, 1'b0, model(32'h20DF1AE5, 1'b0));

        rnd = 1'b1;
        for (int i = 0; i < 25; i++) begin
            a = $urandom;
            rpt = 1'b0;
            case ($urandom_range(4, 0))
                0, 1:    w = keys[$urandom_range(3, 0)];
                2:       w = {a[15:8], ~a[15:8], a[7:0], ~a[7:0]};
                3:       w = a;
                default: begin w = '0; rpt = 1'b1; end
            endcase
            e = model(w, rpt);
            frame($sformatf("rnd%0d", i), w, rpt, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
